// File: rtl/param_seq_detector.sv
// Runtime-programmable serial bit-pattern detector with overlap/non-overlap matching,
// selectable Mealy or Moore output, and a saturating match counter.
module param_seq_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b1011),
  parameter int                 DEF_LEN     = 4,
  parameter int                 CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_moore,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count
);

  // The oldest bit of the window is never compared again, so it is not kept.
  logic [MAX_LEN-2:0] hist_reg;
  logic [MAX_LEN-1:0] pat_reg;
  logic [LEN_W-1:0]   fill_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic               moore_reg;
  logic               z_q_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   len_clamped;
  logic [CNT_W-1:0]   cnt_next;
  logic               consume;
  logic               hit;

  assign window  = {hist_reg, x};
  assign consume = in_valid && !cfg_load;

  // Only the lowest len bits of the window take part in the comparison.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < len_reg);
    end
  endgenerate

  assign hit = consume && (fill_reg >= (len_reg - LEN_W'(1))) &&
               (((window ^ pat_reg) & mask) == '0);

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0)
      len_clamped = LEN_W'(1);
    else if (cfg_len > LEN_W'(MAX_LEN))
      len_clamped = LEN_W'(MAX_LEN);
  end

  always_comb begin
    fill_next = fill_reg;
    if (hit && !overlap_reg)
      fill_next = '0;
    else if (fill_reg < len_reg)
      fill_next = fill_reg + LEN_W'(1);
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_clr)
      cnt_next = '0;
    else if (hit && (cnt_reg != {CNT_W{1'b1}}))
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg    <= '0;
      fill_reg    <= '0;
      pat_reg     <= DEF_PATTERN;
      len_reg     <= LEN_W'(DEF_LEN);
      overlap_reg <= 1'b1;
      moore_reg   <= 1'b0;
      z_q_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      // hit is forced low during cfg_load and idle cycles, which clears z_q then.
      z_q_reg <= hit;
      cnt_reg <= cnt_next;
      if (cfg_load) begin
        pat_reg     <= cfg_pattern;
        len_reg     <= len_clamped;
        overlap_reg <= cfg_overlap;
        moore_reg   <= cfg_moore;
        hist_reg    <= '0;
        fill_reg    <= '0;
      end else if (in_valid) begin
        hist_reg <= window[MAX_LEN-2:0];
        fill_reg <= fill_next;
      end
    end
  end

  assign z           = moore_reg ? z_q_reg : hit;
  assign match_count = cnt_reg;

endmodule

// File: tb/tb_param_seq_detector.sv
// Table-driven bench for param_seq_detector: directed vectors with hand-computed
// z and match_count, plus a hand-written asynchronous reset check.
module tb_param_seq_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       in_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cfg_moore = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       z, z2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_seq_detector dut (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_moore(cfg_moore), .cnt_clr(cnt_clr), .z(z), .match_count(match_count)
  );

  // Narrow-counter instance sharing the same stimulus, checked only where noted.
  param_seq_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_moore(cfg_moore), .cnt_clr(cnt_clr), .z(z2), .match_count(match_count2)
  );

  typedef struct {
    logic       r, x, v, ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov, mo, clr, ez;
    int         ec, ec2;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic r, logic xi, logic v, logic ld, logic [7:0] pat,
                              logic [3:0] len, logic ov, logic mo, logic clr,
                              logic ez, int ec, int ec2);
    vec_t t;
    t.r = r; t.x = xi; t.v = v; t.ld = ld; t.pat = pat; t.len = len;
    t.ov = ov; t.mo = mo; t.clr = clr; t.ez = ez; t.ec = ec; t.ec2 = ec2;
    vq.push_back(t);
  endfunction

  function automatic void bt(logic xi, logic ez, int ec, int ec2 = -1);
    add(1'b0, xi, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, ez, ec, ec2);
  endfunction

  function automatic void gap(logic xi, logic ez, int ec);
    add(1'b0, xi, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, ez, ec, -1);
  endfunction

  // Loads always offer x=1 with in_valid=1 so the discard rule is exercised.
  function automatic void load(logic [7:0] pat, logic [3:0] len, logic ov, logic mo, int ec);
    add(1'b0, 1'b1, 1'b1, 1'b1, pat, len, ov, mo, 1'b0, 1'b0, ec, -1);
  endfunction

  task automatic chk(string name, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d actual %0d required %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    // Reset state
    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    // Defaults 1011 overlapping Mealy: 1,0,1,1,0,1,1
    bt(1, 0, 0); bt(0, 0, 0); bt(1, 0, 0); bt(1, 1, 1);
    bt(0, 0, 1); bt(1, 0, 1); bt(1, 1, 2);
    // Non-overlapping 1011
    load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 2);
    bt(1, 0, 2); bt(0, 0, 2); bt(1, 0, 2); bt(1, 1, 3);
    bt(0, 0, 3); bt(1, 0, 3); bt(1, 0, 3);
    // Moore 111 overlapping, five 1s
    load(8'b0000_0111, 4'd3, 1'b1, 1'b1, 3);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1);
    bt(1, 0, 0); bt(1, 0, 0); bt(1, 0, 1); bt(1, 1, 2); bt(1, 1, 3);
    gap(0, 1, 3); gap(0, 0, 3);
    // Mealy 1011 with two-cycle gaps carrying x=1
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 3);
    bt(1, 0, 3); gap(1, 0, 3); gap(1, 0, 3);
    bt(0, 0, 3); gap(1, 0, 3); gap(1, 0, 3);
    bt(1, 0, 3); gap(1, 0, 3); gap(1, 0, 3);
    bt(1, 1, 4);
    // Load mid-pattern with cfg_len=0 -> len 1, pattern bit 1
    bt(1, 0, 4); bt(0, 0, 4);
    load(8'b0000_0001, 4'd0, 1'b0, 1'b0, 4);
    bt(0, 0, 4); bt(1, 1, 5); bt(1, 1, 6);
    // cfg_len above MAX_LEN clamps to 8
    load(8'b1011_0011, 4'd15, 1'b1, 1'b0, 6);
    bt(1, 0, 6); bt(0, 0, 6); bt(1, 0, 6); bt(1, 0, 6);
    bt(0, 0, 6); bt(0, 0, 6); bt(1, 0, 6); bt(1, 1, 7);
    // Saturation on the 2-bit counter, then cnt_clr together with a hit
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    bt(1, 1, 1, 1); bt(1, 1, 2, 2); bt(1, 1, 3, 3); bt(1, 1, 4, 3);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    bt(0, 0, 0, 0);
    // Reset between bits 3 and 4 of 1011
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 0);
    bt(1, 0, 0); bt(0, 0, 0); bt(1, 0, 0); bt(1, 1, 1);
    bt(1, 0, 1); bt(0, 0, 1); bt(1, 0, 1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    bt(1, 0, 0); bt(0, 0, 0); bt(1, 0, 0); bt(1, 1, 1);

    repeat (2) @(posedge clk);
    foreach (vq[i]) begin
      @(negedge clk);
      reset       = vq[i].r;
      x           = vq[i].x;
      in_valid    = vq[i].v;
      cfg_load    = vq[i].ld;
      cfg_pattern = vq[i].pat;
      cfg_len     = vq[i].len;
      cfg_overlap = vq[i].ov;
      cfg_moore   = vq[i].mo;
      cnt_clr     = vq[i].clr;
      #1;
      chk("z", i, int'(z), int'(vq[i].ez));
      @(posedge clk);
      #1;
      chk("match_count", i, int'(match_count), vq[i].ec);
      if (vq[i].ec2 >= 0)
        chk("match_count_w2", i, int'(match_count2), vq[i].ec2);
      $display("vec %0d rst=%b x=%b v=%b ld=%b clr=%b z=%b cnt=%0d cnt2=%0d",
               i, vq[i].r, vq[i].x, vq[i].v, vq[i].ld, vq[i].clr, z,
               match_count, match_count2);
    end

    // Asynchronous reset between clock edges clears state without waiting for clk.
    @(negedge clk);
    x = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_reset_count", -1, int'(match_count), 0);
    chk("async_reset_count_w2", -1, int'(match_count2), 0);
    chk("async_reset_z", -1, int'(z), 0);
    $display("async reset cnt=%0d cnt2=%0d z=%b", match_count, match_count2, z);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
